muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that produces the 64-bit HI/LO write traffic for the register file.
- Sits in EX and accepts MULT/MULTU/DIV/DIVU from the ID/EX register.
- Raises `busy` so the hazard logic stalls the pipeline.
- Emits a one-cycle `hl_write_enable` + `hl_data` pair that the pipeline carries to the register file's HI/LO write port.

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/muldiv_div_step.sv | 19 +
 rtl/muldiv_unit.sv | 96 +++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation encodings, FSM states and widths for the multiply/divide unit
package muldiv_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 5;
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/muldiv_div_step.sv
// div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract)
module div_step
    import muldiv_pkg::*;
(
    input  logic [DATA_WIDTH:0]   rem_i,
    input  logic                  bit_i,
    input  logic [DATA_WIDTH-1:0] div_i,
    output logic [DATA_WIDTH:0]   rem_o,
    output logic                  q_o
);
    logic [DATA_WIDTH+1:0] sh;
    logic [DATA_WIDTH+1:0] diff;
    always_comb begin
        sh    = {rem_i, bit_i};
        diff  = sh - {2'b0, div_i};
        q_o   = ~diff[DATA_WIDTH+1];
        rem_o = q_o ? diff[DATA_WIDTH:0] : sh[DATA_WIDTH:0];
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle MULT/MULTU/DIV/DIVU unit producing a one-cycle HI/LO write
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [DATA_WIDTH-1:0]   src_a,
    input  logic [DATA_WIDTH-1:0]   src_b,
    input  logic                    flush,
    output logic                    busy,
    output logic                    hl_write_enable,
    output logic [2*DATA_WIDTH-1:0] hl_data
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    state_e                    state_q;
    op_e                       op_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0]     a_q, b_q;
    logic [2*DATA_WIDTH-1:0]   acc_q, hl_q;
    logic [DATA_WIDTH:0]       rem_q, rem_d, msum;
    logic                      neg_q, rneg_q, dz_q, we_q, qbit, sgn;
    logic [DATA_WIDTH-1:0]     quo_d, quo, remv, abs_a, abs_b;
    logic [2*DATA_WIDTH-1:0]   mul_d, res_d;
    div_step u_step (.rem_i(rem_q), .bit_i(a_q[DATA_WIDTH-1]), .div_i(b_q), .rem_o(rem_d), .q_o(qbit));
    always_comb begin
        sgn   = ~op[0];
        abs_a = (sgn & src_a[DATA_WIDTH-1]) ? -src_a : src_a;
        abs_b = (sgn & src_b[DATA_WIDTH-1]) ? -src_b : src_b;
        msum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_d = {msum, acc_q[DATA_WIDTH-1:1]};
        quo_d = {a_q[DATA_WIDTH-2:0], qbit};
        quo   = neg_q ? -quo_d : quo_d;
        remv  = rneg_q ? -rem_d[DATA_WIDTH-1:0] : rem_d[DATA_WIDTH-1:0];
        res_d = !op_q[1] ? (neg_q ? -mul_d : mul_d) :
                dz_q ? {acc_q[DATA_WIDTH-1:0], {DATA_WIDTH{1'b1}}} : {remv, quo};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            hl_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            we_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= CALC;
                    op_q    <= op_e'(op);
                    cnt_q   <= '0;
                    a_q     <= abs_a;
                    b_q     <= abs_b;
                    // divides park the original dividend here for the divide-by-zero result
                    acc_q   <= {{DATA_WIDTH{1'b0}}, op[1] ? src_a : abs_b};
                    rem_q   <= '0;
                    neg_q   <= sgn & (src_a[DATA_WIDTH-1] ^ src_b[DATA_WIDTH-1]);
                    rneg_q  <= sgn & src_a[DATA_WIDTH-1];
                    dz_q    <= src_b == '0;
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (op_q[1]) begin
                        rem_q <= rem_d;
                        a_q   <= quo_d;
                    end else begin
                        acc_q <= mul_d;
                    end
                    if (cnt_q == LAST) begin
                        hl_q    <= res_d;
                        we_q    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy            = state_q != IDLE;
    assign hl_write_enable = we_q;
    assign hl_data         = hl_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, hl_write_enable;
    logic [63:0] hl_data;
    int          tests = 0;
    int          fails = 0;
    bit          en = 1'b0;
    int          m_left = 0;
    logic [63:0] m_data = '0;
    logic [63:0] m_res = '0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .hl_write_enable(hl_write_enable), .hl_data(hl_data)
    );

    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'd0) return sa * sb;
        if (o == 2'd1) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (o == 2'd3) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // m_left: cycles remaining until the unit is idle again; 1 means the write cycle
    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_data <= '0;
        end else if (flush) begin
            m_left <= 0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= 33;
                m_res  <= ref_res(op, src_a, src_b);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_data <= m_res;
        end
    end

    always @(negedge clk) if (en) begin
        tests++;
        if ({busy, hl_write_enable, hl_data} !== {m_left != 0, m_left == 1, m_data}) begin
            fails++;
            $display("FAIL model t=%0t: busy/we/data got %b/%b/%h want %b/%b/%h", $time,
                     busy, hl_write_enable, hl_data, m_left != 0, m_left == 1, m_data);
        end
    end

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1 start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string n, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
        int lat = 0;
        do_start(o, a, b);
        do begin
            @(negedge clk);
            lat++;
        end while (!hl_write_enable && lat < 40);
        check({n, "_lat"}, 64'(lat - 1), 64'd32);
        check(n, hl_data, exp);
        @(negedge clk);
        check({n, "_we_off"}, 64'(hl_write_enable), 64'd0);
        check({n, "_busy_off"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int pulses;
        logic [63:0] d;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(hl_write_enable), 64'd0);
        check("rst_data", hl_data, 64'd0);
        check("model_mult", ref_res(2'd0, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
        check("model_div", ref_res(2'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        @(posedge clk);
        #1 rst = 1'b0;

        run("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
        run("divu_100_7", 2'd3, 32'd100, 32'd7, 64'h00000002_0000000E);
        run("div_neg7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run("div_wrap", 2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run("mult_min", 2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        run("divu_zero", 2'd3, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);

        do_start(2'd0, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_we", 64'(hl_write_enable), 64'd0);
        check("flush_data", hl_data, 64'h12345678_FFFFFFFF);
        run("multu_after_flush", 2'd1, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);

        do_start(2'd3, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        d = '0;
        repeat (40) begin
            @(negedge clk);
            if (hl_write_enable) begin
                pulses++;
                d = hl_data;
            end
        end
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_data", d, 64'h00000002_0000000E);

        do_start(2'd0, 32'd9, 32'd9);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_we", 64'(hl_write_enable), 64'd0);
        check("midrst_data", hl_data, 64'd0);

        @(posedge clk);
        #1 start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("start_flush_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            start = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 63) == 0;
            rst   = $urandom_range(0, 999) == 0;
            op    = 2'($urandom);
            case ($urandom_range(0, 7))
                0: src_a = 32'd0;
                1: src_a = 32'h80000000;
                2: src_a = 32'hFFFFFFFF;
                default: src_a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: src_b = 32'd0;
                1: src_b = 32'hFFFFFFFF;
                2: src_b = 32'd1;
                default: src_b = $urandom;
            endcase
        end
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
